// File: rtl/ras_ckpt_if.sv
// Bundle of RAS control, checkpoint/restore requests and prediction outputs
// shared between the fetch-1 branch logic (master) and the stack (slave).
interface ras_ckpt_if #(
   parameter int ADDR_W = 64,
   parameter int NCKPT  = 4
);
   localparam int IW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

   logic [1:0]        ras_ctl_i;
   logic [ADDR_W-1:0] push_pc_i;
   logic              ckpt_we_i;
   logic [IW-1:0]     ckpt_id_i;
   logic              restore_i;
   logic [IW-1:0]     restore_id_i;
   logic [ADDR_W-1:0] top_o;
   logic              empty_o;
   logic              full_o;
   logic              overflow_o;
   logic              underflow_o;

   modport master (
      output ras_ctl_i, push_pc_i, ckpt_we_i, ckpt_id_i, restore_i, restore_id_i,
      input  top_o, empty_o, full_o, overflow_o, underflow_o
   );

   modport slave (
      input  ras_ctl_i, push_pc_i, ckpt_we_i, ckpt_id_i, restore_i, restore_id_i,
      output top_o, empty_o, full_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/ras_ckpt.sv
// Return-address stack with per-branch checkpoints of {tos, count, top}.
// A restore repairs pointer, count and the single top entry; deeper entries
// that were clobbered by wrong-path pushes are deliberately left as they are.
module ras_ckpt #(
   parameter int ADDR_W = 64,
   parameter int DEPTH  = 8,
   parameter int NCKPT  = 4
) (
   input logic        clk_i,
   input logic        rst_n_i,
   ras_ckpt_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int IW = (NCKPT > 1) ? $clog2(NCKPT) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [ADDR_W-1:0] stack [DEPTH];
   logic [PW-1:0]     tos;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     ck_tos [NCKPT];
   logic [CW-1:0]     ck_cnt [NCKPT];
   logic [ADDR_W-1:0] ck_top [NCKPT];
   logic              overflow_q;
   logic              underflow_q;

   logic [ADDR_W-1:0] ret;
   logic [PW-1:0]     tos_nx;
   logic [CW-1:0]     cnt_nx;
   logic              wr_en;
   logic [PW-1:0]     wr_idx;
   logic [ADDR_W-1:0] wr_data;
   logic              ck_wr;
   logic [ADDR_W-1:0] top_nx;
   logic              overflow_nx;
   logic              underflow_nx;

   assign ret = bus.push_pc_i + ADDR_W'(4);

   // Work out the post-edge state; restore overrides every other request.
   always_comb begin
      tos_nx       = tos;
      cnt_nx       = cnt;
      wr_en        = 1'b0;
      wr_idx       = tos;
      wr_data      = ret;
      ck_wr        = 1'b0;
      overflow_nx  = 1'b0;
      underflow_nx = 1'b0;
      if (bus.restore_i) begin
         tos_nx  = ck_tos[bus.restore_id_i];
         cnt_nx  = ck_cnt[bus.restore_id_i];
         wr_en   = 1'b1;
         wr_idx  = ck_tos[bus.restore_id_i];
         wr_data = ck_top[bus.restore_id_i];
      end else begin
         ck_wr = bus.ckpt_we_i;
         case (bus.ras_ctl_i)
            2'b01: begin
               tos_nx      = tos + PW'(1);
               wr_en       = 1'b1;
               wr_idx      = tos + PW'(1);
               cnt_nx      = (cnt == FULL_CNT) ? cnt : cnt + CW'(1);
               overflow_nx = (cnt == FULL_CNT);
            end
            2'b10: begin
               if (cnt != '0) begin
                  tos_nx = tos - PW'(1);
                  cnt_nx = cnt - CW'(1);
               end else begin
                  underflow_nx = 1'b1;
               end
            end
            2'b11: begin
               wr_en  = 1'b1;
               wr_idx = tos;
               cnt_nx = (cnt == '0) ? CW'(1) : cnt;
            end
            default: ;
         endcase
      end
      top_nx = (wr_en && (wr_idx == tos_nx)) ? wr_data : stack[tos_nx];
   end

   // Stack storage, pointer, count and event pulses.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
         tos         <= '0;
         cnt         <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_en) stack[wr_idx] <= wr_data;
         tos         <= tos_nx;
         cnt         <= cnt_nx;
         overflow_q  <= overflow_nx;
         underflow_q <= underflow_nx;
      end
   end

   // Checkpoint slots capture the state as it will be after this edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < NCKPT; i++) begin
            ck_tos[i] <= '0;
            ck_cnt[i] <= '0;
            ck_top[i] <= '0;
         end
      end else if (ck_wr) begin
         ck_tos[bus.ckpt_id_i] <= tos_nx;
         ck_cnt[bus.ckpt_id_i] <= cnt_nx;
         ck_top[bus.ckpt_id_i] <= top_nx;
      end
   end

   assign bus.top_o       = (cnt == '0) ? '0 : stack[tos];
   assign bus.empty_o     = (cnt == '0);
   assign bus.full_o      = (cnt == FULL_CNT);
   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;
endmodule

// File: tb/tb_ras_ckpt.sv
// Randomised and directed bench for ras_ckpt against a behavioural stack model.
module tb_ras_ckpt;
   localparam int AW = 64;
   localparam int D  = 8;
   localparam int NC = 4;

   logic clk;
   logic rst_n;

   ras_ckpt_if #(.ADDR_W(AW), .NCKPT(NC)) bus ();

   ras_ckpt #(.ADDR_W(AW), .DEPTH(D), .NCKPT(NC)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: spec-level state kept as plain integers.
   logic [AW-1:0] m_stack [D];
   int            m_tos;
   int            m_cnt;
   int            c_tos [NC];
   int            c_cnt [NC];
   logic [AW-1:0] c_top [NC];
   logic          m_ovf;
   logic          m_unf;

   int n_vec;
   int n_err;
   bit chk_en;

   function automatic logic [AW-1:0] model_top();
      return (m_cnt == 0) ? '0 : m_stack[m_tos];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_stack[i] = '0;
      for (int i = 0; i < NC; i++) begin
         c_tos[i] = 0;
         c_cnt[i] = 0;
         c_top[i] = '0;
      end
      m_tos = 0;
      m_cnt = 0;
      m_ovf = 0;
      m_unf = 0;
   endtask

   task automatic model_step(input logic [1:0] ctl, input logic [AW-1:0] pc,
                             input logic we, input int id, input logic rs, input int rid);
      logic [AW-1:0] r;
      r     = pc + 64'd4;
      m_ovf = 0;
      m_unf = 0;
      if (rs) begin
         m_tos = c_tos[rid];
         m_cnt = c_cnt[rid];
         m_stack[m_tos] = c_top[rid];
      end else begin
         if (ctl == 2'b01) begin
            m_ovf = (m_cnt == D);
            m_tos = (m_tos + 1) % D;
            m_stack[m_tos] = r;
            if (m_cnt < D) m_cnt = m_cnt + 1;
         end else if (ctl == 2'b10) begin
            if (m_cnt == 0) m_unf = 1;
            else begin
               m_tos = (m_tos + D - 1) % D;
               m_cnt = m_cnt - 1;
            end
         end else if (ctl == 2'b11) begin
            m_stack[m_tos] = r;
            if (m_cnt == 0) m_cnt = 1;
         end
         if (we) begin
            c_tos[id] = m_tos;
            c_cnt[id] = m_cnt;
            c_top[id] = m_stack[m_tos];
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus(input logic [1:0] ctl, input logic [AW-1:0] pc,
                                input logic we, input int id, input logic rs, input int rid);
      bus.ras_ctl_i    = ctl;
      bus.push_pc_i    = pc;
      bus.ckpt_we_i    = we;
      bus.ckpt_id_i    = 2'(id);
      bus.restore_i    = rs;
      bus.restore_id_i = 2'(rid);
      @(posedge clk);
      model_step(ctl, pc, we, id, rs, rid);
      @(negedge clk);
      bus.ras_ctl_i = 2'b00;
      bus.ckpt_we_i = 1'b0;
      bus.restore_i = 1'b0;
   endtask

   task automatic push(input logic [AW-1:0] pc);
      applyStimulus(2'b01, pc, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic pop();
      applyStimulus(2'b10, '0, 1'b0, 0, 1'b0, 0);
   endtask

   // Literal expectation checked against both the DUT and the model.
   task automatic pinTop(input string name, input logic [AW-1:0] lit);
      checkOutput({name, "_dut"}, bus.top_o, lit);
      checkOutput({name, "_model"}, model_top(), lit);
   endtask

   task automatic pinCount(input string name, input int lit);
      checkOutput(name, 64'(m_cnt), 64'(lit));
   endtask

   // Cycle-by-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         checkOutput("top", bus.top_o, model_top());
         checkOutput("empty", 64'(bus.empty_o), 64'(m_cnt == 0));
         checkOutput("full", 64'(bus.full_o), 64'(m_cnt == D));
         checkOutput("overflow", 64'(bus.overflow_o), 64'(m_ovf));
         checkOutput("underflow", 64'(bus.underflow_o), 64'(m_unf));
      end
   end

   initial begin
      n_vec  = 0;
      n_err  = 0;
      chk_en = 0;
      rst_n  = 1'b0;
      bus.ras_ctl_i    = 2'b00;
      bus.push_pc_i    = '0;
      bus.ckpt_we_i    = 1'b0;
      bus.ckpt_id_i    = '0;
      bus.restore_i    = 1'b0;
      bus.restore_id_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      checkOutput("rst_top", bus.top_o, 64'h0);
      checkOutput("rst_empty", 64'(bus.empty_o), 64'd1);
      checkOutput("rst_full", 64'(bus.full_o), 64'd0);
      rst_n  = 1'b1;
      chk_en = 1;

      // Basic push/pop.
      push(64'h1000);
      push(64'h2000);
      push(64'h3000);
      pinTop("push3", 64'h3004);
      pop();
      pop();
      pinTop("pop2", 64'h1004);
      pinCount("pop2_cnt", 1);
      pop();
      pinTop("pop3", 64'h0);
      checkOutput("pop3_empty", 64'(bus.empty_o), 64'd1);

      // Underflow pulse lasts one cycle.
      pop();
      checkOutput("unf_pulse", 64'(bus.underflow_o), 64'd1);
      pinCount("unf_cnt", 0);
      applyStimulus(2'b00, '0, 1'b0, 0, 1'b0, 0);
      checkOutput("unf_clear", 64'(bus.underflow_o), 64'd0);

      // Overflow with nine pushes, then drain.
      for (int k = 1; k <= 9; k++) push(64'(k * 'h100));
      checkOutput("ovf_pulse", 64'(bus.overflow_o), 64'd1);
      checkOutput("ovf_full", 64'(bus.full_o), 64'd1);
      for (int k = 0; k < 8; k++) begin
         pinTop("drain", 64'h904 - 64'(k * 'h100));
         pop();
      end
      checkOutput("drain_empty", 64'(bus.empty_o), 64'd1);
      pop();
      checkOutput("drain_unf", 64'(bus.underflow_o), 64'd1);

      // Pop+push (coroutine).
      push(64'h1000);
      applyStimulus(2'b11, 64'h5000, 1'b0, 0, 1'b0, 0);
      pinTop("coro", 64'h5004);
      pinCount("coro_cnt", 1);
      pop();
      applyStimulus(2'b11, 64'h7000, 1'b0, 0, 1'b0, 0);
      pinTop("coro_empty", 64'h7004);
      pinCount("coro_empty_cnt", 1);
      pop();

      // Checkpoint and restore; push in the restore cycle is ignored.
      applyStimulus(2'b01, 64'h1000, 1'b1, 2, 1'b0, 0);
      pop();
      push(64'hA000);
      applyStimulus(2'b01, 64'hB000, 1'b0, 0, 1'b1, 2);
      pinTop("restore", 64'h1004);
      pinCount("restore_cnt", 1);
      checkOutput("restore_novf", 64'(bus.overflow_o), 64'd0);

      // Return address wraps to zero while the stack is non-empty.
      push(64'hFFFF_FFFF_FFFF_FFFC);
      pinTop("wrap", 64'h0);
      checkOutput("wrap_empty", 64'(bus.empty_o), 64'd0);

      // Asynchronous reset in the middle of a cycle.
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      checkOutput("async_rst_top", bus.top_o, 64'h0);
      checkOutput("async_rst_empty", 64'(bus.empty_o), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised traffic including restores and checkpoint overwrites.
      for (int i = 0; i < 600; i++) begin
         logic [1:0]    ctl;
         logic [AW-1:0] pc;
         logic          rs;
         ctl = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
         else pc = {$urandom, $urandom};
         rs = ($urandom_range(0, 7) == 0);
         applyStimulus(ctl, pc, 1'($urandom_range(0, 1)), int'($urandom_range(0, NC - 1)),
                       rs, int'($urandom_range(0, NC - 1)));
      end

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/ras_ckpt.md
# ras_ckpt

Return-address stack with speculative checkpoint and repair, parametrised in address width, stack depth and checkpoint count. It sits in fetch 1 beside the per-way branch decoders. Each cycle it applies the 2-bit RAS control from the selected branch (none / push / pop / pop+push) and supplies the predicted return target. On a branch mispredict, the back end restores the pointer, count and top entry from a per-branch checkpoint.

## Interface
Parameters:
- ADDR_W, 64: address width.
- DEPTH, 8: stack entries; power of two, ≥2.
- NCKPT, 4: checkpoint slots; power of two.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- ras_ctl_i  in  2  00 none, 01 push, 10 pop, 11 pop+push (coroutine).
- push_pc_i  in  ADDR_W  PC of the pushing instruction; the stored return address is push_pc_i+4.
- ckpt_we_i  in  1  record the checkpoint this cycle.
- ckpt_id_i  in  log2(NCKPT)  slot to write.
- restore_i  in  1  mispredict repair request.
- restore_id_i  in  log2(NCKPT)  slot to restore from.
- top_o  out  ADDR_W  predicted return target; 0 when empty.
- empty_o  out  1  count==0.
- full_o  out  1  count==DEPTH.
- overflow_o  out  1  one-cycle pulse: push dropped the oldest entry.
- underflow_o  out  1  one-cycle pulse: pop while empty.

## Operation
- State:
  - stack[DEPTH] of ADDR_W.
  - tos pointer, log2(DEPTH) bits; points at the current top.
  - count, 0..DEPTH.
  - ckpt[NCKPT], each holding {tos, count, top value}.
- ret = push_pc_i + 4, computed modulo 2^ADDR_W (wraps).
- 00: no change.
- 01 push:
  - tos <= tos+1 (mod DEPTH); stack[tos+1] <= ret.
  - count <= min(count+1, DEPTH).
  - If count was DEPTH, the oldest entry is overwritten and overflow_o pulses.
- 10 pop:
  - If count>0: tos <= tos-1 (mod DEPTH); count <= count-1.
  - If count==0: no state change; underflow_o pulses.
- 11 pop+push:
  - stack[tos] <= ret; tos unchanged.
  - count <= max(count, 1). On empty this creates one entry at the current tos.
- Checkpoint (ckpt_we_i=1, restore_i=0):
  - ckpt[ckpt_id_i] <= post-op {tos', count', stack'[tos']}, i.e. the state after this cycle's ras_ctl_i is applied.
  - Writing an occupied slot overwrites it; slots carry no valid bit.
- Restore (restore_i=1):
  - tos <= ckpt.tos; count <= ckpt.count; stack[ckpt.tos] <= ckpt.top.
  - Entries other than the top are not repaired.
  - ras_ctl_i and ckpt_we_i are ignored in that cycle.
  - No overflow or underflow pulse occurs.
- top_o = (count==0) ? 0 : stack[tos]. It is combinational from registers only, with no input-to-output path.

## Timing
- Reset:
  - tos=0, count=0, all stack and checkpoint entries 0.
  - top_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
  - Reset mid-operation discards all entries and checkpoints immediately (asynchronous).
- All updates occur at the rising edge of clk_i.
- top_o, empty_o and full_o reflect an op or restore at edge N from edge N onward, so the decoder sees the new top in the following cycle.
- overflow_o and underflow_o are registered. Each is high for exactly the one cycle following the offending edge.
- Back-to-back ops every cycle are supported with no bubbles.
- Wrap-around: tos wraps DEPTH-1 -> 0 on push and 0 -> DEPTH-1 on pop, with no error.
- Priority: restore_i > ras_ctl_i / ckpt_we_i.
- Restore to a checkpoint written in the same cycle is not possible, because the write is ignored. A checkpoint written at edge N is restorable from edge N+1.

## Test plan
- Reset, then push 0x1000, 0x2000, 0x3000 -> top_o=0x3004. Pop twice -> top_o=0x1004, count=1. Pop once more -> empty_o=1, top_o=0.
- Pop on empty -> underflow_o high one cycle, tos and count unchanged, top_o=0.
- DEPTH=8: push PCs 0x100..0x900 in steps of 0x100 (9 pushes) -> overflow_o pulses on the 9th push and full_o=1. Then 8 pops return 0x904 down to 0x204; a 9th pop underflows.
- Push 0x1000, then issue op 11 with push_pc_i=0x5000 -> top_o=0x5004, count unchanged at 1. Op 11 on empty with push_pc_i=0x7000 -> count=1, top_o=0x7004.
- Restore and repair sequence:
  - Push 0x1000 with ckpt_we_i=1, id 2 (saves top=0x1004, count=1).
  - Pop, then push 0xA000.
  - Restore id 2 -> top_o=0x1004, count=1.
  - Asserting ras_ctl_i=01 in the restore cycle has no effect.
- Push with push_pc_i=0xFFFF_FFFF_FFFF_FFFC -> top_o=0x0 and empty_o=0. The address wraps; top_o is 0 while the stack is non-empty.
